// File: rtl/axi_bridge.sv
// axi_bridge: loads a frame of N 16-bit samples from a write channel into RAM.
// It then waits for an external calculation to finish, and finally streams
// N words back out of RAM on a read channel.
//
// Handshake: a beat transfers on a rising edge where the sender's valid and the
// receiver's ready are both high in the same cycle; neither side may assume a
// transfer otherwise, and the sender holds its data until the transfer happens.
module axi_bridge #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [15:0]           i_AWDATA,
  input  logic                  i_AWVALID,
  input  logic [11:0]           i_SAMPLES_NUMBER,
  input  logic                  i_CALC_END,
  input  logic                  i_ARREADY,
  input  logic [DATA_WIDTH-1:0] i_DATA_FROM_RAM,
  output logic                  o_AWREADY,
  output logic [1:0]            o_AWBURST,
  output logic [1:0]            o_ARBURST,
  output logic [15:0]           o_SAMPLE_ram,
  output logic [11:0]           o_SAMPLE_INDEX_ram,
  output logic                  o_WRITE_ram,
  output logic                  o_READ_ram,
  output logic                  o_DATA_LOADED,
  output logic                  o_ARVALID,
  output logic [DATA_WIDTH-1:0] o_ARDATA,
  output logic [1:0]            current_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_WAIT = 2'd2,
    S_SEND = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [11:0] r_cnt;
  logic [11:0] w_next_cnt;
  logic [11:0] r_n_lat;
  logic [11:0] w_next_n_lat;

  logic [11:0] w_n_eff;
  logic        w_loading;
  logic        w_awready;
  logic        w_wr_beat;
  logic        w_send;
  logic        w_rd_beat;

  // The frame length comes straight from the input until the first beat is
  // taken; after that the latched copy is used so mid-frame changes are ignored.
  assign w_n_eff   = (r_state == S_IDLE) ? i_SAMPLES_NUMBER : r_n_lat;
  assign w_loading = (r_state == S_IDLE) || (r_state == S_LOAD);
  assign w_awready = !i_rst && w_loading && (w_n_eff != 12'd0);
  assign w_wr_beat = i_AWVALID && w_awready;
  assign w_send    = !i_rst && (r_state == S_SEND);
  assign w_rd_beat = w_send && i_ARREADY;

  // State, counter and latched length registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 12'd0;
      r_n_lat <= 12'd0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
      r_n_lat <= w_next_n_lat;
    end
  end

  // Next-state logic: advance only on accepted beats, otherwise hold.
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_next_n_lat = r_n_lat;
    case (r_state)
      S_IDLE, S_LOAD: begin
        if (w_wr_beat) begin
          if (r_state == S_IDLE) begin
            w_next_n_lat = i_SAMPLES_NUMBER;
          end
          if (r_cnt == w_n_eff - 12'd1) begin
            w_next_cnt   = 12'd0;
            w_next_state = S_WAIT;
          end else begin
            w_next_cnt   = r_cnt + 12'd1;
            w_next_state = S_LOAD;
          end
        end
      end
      S_WAIT: begin
        if (i_CALC_END) begin
          w_next_state = S_SEND;
          w_next_cnt   = 12'd0;
        end
      end
      S_SEND: begin
        if (w_rd_beat) begin
          if (r_cnt == r_n_lat - 12'd1) begin
            w_next_cnt   = 12'd0;
            w_next_state = S_IDLE;
          end else begin
            w_next_cnt = r_cnt + 12'd1;
          end
        end
      end
      default: begin
        w_next_state = S_IDLE;
        w_next_cnt   = 12'd0;
      end
    endcase
  end

  // Output decode; during reset the outputs look like IDLE with strobes off.
  always_comb begin
    o_AWREADY          = w_awready;
    o_AWBURST          = 2'b01;
    o_ARBURST          = 2'b01;
    o_SAMPLE_ram       = i_AWDATA;
    o_WRITE_ram        = w_wr_beat;
    o_SAMPLE_INDEX_ram = i_rst ? 12'd0 : r_cnt;
    o_READ_ram         = w_send;
    o_ARVALID          = w_send;
    o_ARDATA           = w_send ? i_DATA_FROM_RAM : '0;
    o_DATA_LOADED      = !i_rst && (r_state == S_WAIT);
    current_state      = r_state;
  end

endmodule

// File: tb/tb_axi_bridge.sv
// Testbench for axi_bridge: directed frames with a queue-based scoreboard.
module tb_axi_bridge;

  localparam int DW = 32;

  logic          i_clk;
  logic          i_rst;
  logic [15:0]   i_AWDATA;
  logic          i_AWVALID;
  logic [11:0]   i_SAMPLES_NUMBER;
  logic          i_CALC_END;
  logic          i_ARREADY;
  logic [DW-1:0] i_DATA_FROM_RAM;
  logic          o_AWREADY;
  logic [1:0]    o_AWBURST;
  logic [1:0]    o_ARBURST;
  logic [15:0]   o_SAMPLE_ram;
  logic [11:0]   o_SAMPLE_INDEX_ram;
  logic          o_WRITE_ram;
  logic          o_READ_ram;
  logic          o_DATA_LOADED;
  logic          o_ARVALID;
  logic [DW-1:0] o_ARDATA;
  logic [1:0]    current_state;

  int checks = 0;
  int errors = 0;

  // Expected write beats {index, data} and read beats {index, data}.
  logic [27:0] wr_q[$];
  logic [43:0] rd_q[$];

  axi_bridge #(.DATA_WIDTH(DW)) dut (
    .i_clk              (i_clk),
    .i_rst              (i_rst),
    .i_AWDATA           (i_AWDATA),
    .i_AWVALID          (i_AWVALID),
    .i_SAMPLES_NUMBER   (i_SAMPLES_NUMBER),
    .i_CALC_END         (i_CALC_END),
    .i_ARREADY          (i_ARREADY),
    .i_DATA_FROM_RAM    (i_DATA_FROM_RAM),
    .o_AWREADY          (o_AWREADY),
    .o_AWBURST          (o_AWBURST),
    .o_ARBURST          (o_ARBURST),
    .o_SAMPLE_ram       (o_SAMPLE_ram),
    .o_SAMPLE_INDEX_ram (o_SAMPLE_INDEX_ram),
    .o_WRITE_ram        (o_WRITE_ram),
    .o_READ_ram         (o_READ_ram),
    .o_DATA_LOADED      (o_DATA_LOADED),
    .o_ARVALID          (o_ARVALID),
    .o_ARDATA           (o_ARDATA),
    .current_state      (current_state)
  );

  // RAM model: asynchronous read returning a recognisable tag plus the address.
  assign i_DATA_FROM_RAM = {20'hA5A5A, o_SAMPLE_INDEX_ram};

  // Clock and reset-related setup.
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic sample();
    @(negedge i_clk);
  endtask

  task automatic check(input string name, input logic [43:0] act, input logic [43:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compares every RAM write and every completed read beat.
  always @(negedge i_clk) begin
    if (o_WRITE_ram) begin
      checks++;
      if (wr_q.size() == 0) begin
        errors++;
        $display("FAIL wr_extra: got write idx %0d data %0h expected none", o_SAMPLE_INDEX_ram, o_SAMPLE_ram);
      end else begin
        logic [27:0] e;
        e = wr_q.pop_front();
        if ({o_SAMPLE_INDEX_ram, o_SAMPLE_ram} !== e) begin
          errors++;
          $display("FAIL wr_beat: got %0h expected %0h", {o_SAMPLE_INDEX_ram, o_SAMPLE_ram}, e);
        end
      end
    end
    if (o_ARVALID && i_ARREADY) begin
      checks++;
      if (rd_q.size() == 0) begin
        errors++;
        $display("FAIL rd_extra: got read idx %0d data %0h expected none", o_SAMPLE_INDEX_ram, o_ARDATA);
      end else begin
        logic [43:0] e;
        e = rd_q.pop_front();
        if ({o_SAMPLE_INDEX_ram, o_ARDATA} !== e || o_READ_ram !== 1'b1) begin
          errors++;
          $display("FAIL rd_beat: got %0h rd %0b expected %0h rd 1", {o_SAMPLE_INDEX_ram, o_ARDATA}, o_READ_ram, e);
        end
      end
    end
  end

  // Drive a write pattern; bit i of pat says whether cycle i carries a beat.
  task automatic write_beats(input int len, input logic [15:0] pat, input logic [15:0] base);
    int idx = 0;
    for (int i = 0; i < len; i++) begin
      if (pat[i]) begin
        i_AWVALID = 1'b1;
        i_AWDATA  = base + 16'(idx);
        wr_q.push_back({12'(idx), 16'(base + 16'(idx))});
        idx++;
      end else begin
        i_AWVALID = 1'b0;
        i_AWDATA  = 16'hDEAD;
        sample();
        check("gap_index", 44'(o_SAMPLE_INDEX_ram), 44'(idx));
      end
      tick();
    end
    i_AWVALID = 1'b0;
  endtask

  // Pulse the calculation-done input from WAIT; the next cycle is SEND.
  task automatic start_send();
    i_CALC_END = 1'b1;
    tick();
    i_CALC_END = 1'b0;
  endtask

  // Drive a read-ready pattern; stalls must keep the index and valid steady.
  task automatic read_beats(input int len, input logic [15:0] pat);
    int idx = 0;
    for (int i = 0; i < len; i++) begin
      i_ARREADY = pat[i];
      if (pat[i]) begin
        rd_q.push_back({12'(idx), 20'hA5A5A, 12'(idx)});
        idx++;
      end else begin
        sample();
        check("stall_index", 44'(o_SAMPLE_INDEX_ram), 44'(idx));
        check("stall_arvalid", 44'(o_ARVALID), 44'd1);
      end
      tick();
    end
    i_ARREADY = 1'b0;
  endtask

  // Directed sequence.
  initial begin
    i_rst            = 1'b1;
    i_AWDATA         = 16'h0;
    i_AWVALID        = 1'b1;
    i_SAMPLES_NUMBER = 12'd10;
    i_CALC_END       = 1'b0;
    i_ARREADY        = 1'b0;

    // Reset held for two edges; AWREADY must be forced off despite N=10.
    tick();
    sample();
    check("rst_state", 44'(current_state), 44'd0);
    check("rst_awready", 44'(o_AWREADY), 44'd0);
    check("rst_write", 44'(o_WRITE_ram), 44'd0);
    check("rst_arvalid", 44'(o_ARVALID), 44'd0);
    check("rst_read", 44'(o_READ_ram), 44'd0);
    check("rst_loaded", 44'(o_DATA_LOADED), 44'd0);
    check("rst_index", 44'(o_SAMPLE_INDEX_ram), 44'd0);
    check("bursts", 44'({o_AWBURST, o_ARBURST}), 44'h5);
    tick();
    i_rst     = 1'b0;
    i_AWVALID = 1'b0;

    // Frame 1: N=10 back-to-back, then WAIT.
    write_beats(10, 16'h03FF, 16'h0100);
    sample();
    check("f1_state", 44'(current_state), 44'd2);
    check("f1_loaded", 44'(o_DATA_LOADED), 44'd1);
    check("f1_awready", 44'(o_AWREADY), 44'd0);
    // A new length during WAIT must not change the frame being sent.
    i_SAMPLES_NUMBER = 12'd3;
    tick();
    start_send();
    sample();
    check("f1_send_state", 44'(current_state), 44'd3);
    read_beats(10, 16'h03FF);
    sample();
    check("f1_idle", 44'(current_state), 44'd0);

    // Frame 2: N=5 with write gaps and a 3-cycle read stall.
    i_SAMPLES_NUMBER = 12'd5;
    write_beats(8, 16'b1100_1101, 16'h2000);
    sample();
    check("f2_state", 44'(current_state), 44'd2);
    // Calculation-done is only meaningful in WAIT; no stray reads before it.
    start_send();
    read_beats(8, 16'b1111_0001);
    sample();
    check("f2_idle", 44'(current_state), 44'd0);

    // N=0: never accepts, calc-end in IDLE is ignored.
    i_SAMPLES_NUMBER = 12'd0;
    i_AWVALID        = 1'b1;
    i_AWDATA         = 16'hBEEF;
    i_CALC_END       = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sample();
      check("n0_awready", 44'(o_AWREADY), 44'd0);
      tick();
    end
    i_AWVALID  = 1'b0;
    i_CALC_END = 1'b0;
    sample();
    check("n0_state", 44'(current_state), 44'd0);

    // N=1: one beat goes straight to WAIT, one read returns to IDLE.
    i_SAMPLES_NUMBER = 12'd1;
    write_beats(1, 16'h0001, 16'h0777);
    sample();
    check("n1_state", 44'(current_state), 44'd2);
    start_send();
    read_beats(1, 16'h0001);
    sample();
    check("n1_idle", 44'(current_state), 44'd0);

    // Reset during SEND at index 4.
    i_SAMPLES_NUMBER = 12'd8;
    write_beats(8, 16'h00FF, 16'h3000);
    start_send();
    read_beats(4, 16'h000F);
    sample();
    check("mid_index", 44'(o_SAMPLE_INDEX_ram), 44'd4);
    check("mid_state", 44'(current_state), 44'd3);
    i_rst     = 1'b1;
    i_ARREADY = 1'b1;
    sample();
    check("rstsend_arvalid", 44'(o_ARVALID), 44'd0);
    check("rstsend_ardata", 44'(o_ARDATA), 44'd0);
    tick();
    i_rst     = 1'b0;
    i_ARREADY = 1'b0;
    sample();
    check("post_rst_state", 44'(current_state), 44'd0);
    check("post_rst_index", 44'(o_SAMPLE_INDEX_ram), 44'd0);
    check("post_rst_arvalid", 44'(o_ARVALID), 44'd0);

    // Every expected beat must have been observed.
    tick();
    sample();
    check("wr_q_empty", 44'(wr_q.size()), 44'd0);
    check("rd_q_empty", 44'(rd_q.size()), 44'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
